// File: rtl/ir_tx_sequencer.sv
// IrDA SIR transmit sequencer: frames bytes (start, data LSB-first, stop) onto ir_tx using baud generator ticks.
// Optional even-parity bit is built in when IR_TX_PARITY_EN is defined.
module ir_tx_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 baud_enable,
    input  logic                 baud_full,
    input  logic                 baud_pulse,
    output logic                 ir_tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef IR_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [CW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 cur_bit;
    logic                 tick;
`ifdef IR_TX_PARITY_EN
    logic                 parity_bit;
`endif

    // Generator ticks only count while this block has the generator enabled.
    assign tick = baud_enable & baud_full;

    always_comb begin
        cur_bit = 1'b1;
        case (state)
            START:   cur_bit = 1'b0;
            DATA:    cur_bit = shift[0];
`ifdef IR_TX_PARITY_EN
            PARITY:  cur_bit = parity_bit;
`endif
            default: cur_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            tx_ready    <= 1'b1;
            baud_enable <= 1'b0;
            busy        <= 1'b0;
            ir_tx       <= 1'b0;
            frame_done  <= 1'b0;
`ifdef IR_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            ir_tx      <= (state != IDLE) & ~cur_bit & baud_pulse & baud_enable;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift       <= tx_data;
                        bit_cnt     <= '0;
                        stop_cnt    <= 1'b0;
                        tx_ready    <= 1'b0;
                        baud_enable <= 1'b1;
                        busy        <= 1'b1;
                        state       <= START;
`ifdef IR_TX_PARITY_EN
                        parity_bit  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (tick) state <= DATA;
                end
                DATA: begin
                    if (tick) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef IR_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef IR_TX_PARITY_EN
                PARITY: begin
                    if (tick) state <= STOP;
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (int'(stop_cnt) == STOP_BITS - 1) begin
                            state       <= IDLE;
                            frame_done  <= 1'b1;
                            tx_ready    <= 1'b1;
                            baud_enable <= 1'b0;
                            busy        <= 1'b0;
                            stop_cnt    <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_tx_sequencer.sv
// Self-checking bench for ir_tx_sequencer with a shortened behavioural baud generator
// and a bit-period waveform model derived from the frame format.
module tb_ir_tx_sequencer;

    localparam int DB = 8;
    localparam int SB = 1;
    localparam int P  = 32;
    localparam int WS = 13;
    localparam int W  = 6;
`ifdef IR_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + DB + PB + SB;
    localparam logic [7:0] MASK = 8'((1 << DB) - 1);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, baud_enable, baud_full, baud_pulse, ir_tx, busy, frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ir_tx_sequencer #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data[DB-1:0]),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .baud_enable (baud_enable),
        .baud_full   (baud_full),
        .baud_pulse  (baud_pulse),
        .ir_tx       (ir_tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Generator model: counter cleared while disabled; random junk on its outputs when disabled.
    logic [5:0] gcnt;
    logic [1:0] noise = '0;
    always @(posedge clock or negedge reset) begin
        if (!reset)            gcnt <= '0;
        else if (!baud_enable) gcnt <= '0;
        else                   gcnt <= (gcnt == 6'(P - 1)) ? '0 : gcnt + 6'd1;
    end
    always @(posedge clock) noise <= 2'($urandom);
    assign baud_full  = baud_enable ? (gcnt == 6'(P - 1)) : noise[0];
    assign baud_pulse = baud_enable ? (gcnt >= 6'(WS) && gcnt < 6'(WS + W)) : noise[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int i);
        logic [7:0] m;
        m = d & MASK;
        if (i == 0) return 1'b0;
        if (i <= DB) return d[i-1];
        if (PB == 1 && i == DB + 1) return ^m;
        return 1'b1;
    endfunction

    // ir_tx during the k-th cycle after the accepting edge.
    function automatic logic exp_ir(input logic [7:0] d, input int k);
        int j;
        if (k < 1) return 1'b0;
        j = k - 1;
        if (j >= NBITS * P) return 1'b0;
        return !exp_bit(d, j / P) && (j % P >= WS) && (j % P < WS + W);
    endfunction

    task automatic do_accept(input logic [7:0] d);
        int w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        while (!tx_ready && w < 1000) begin
            @(negedge clock);
            w++;
        end
        check("accept_wait", 32'(w < 1000), 32'd1);
        @(posedge clock);
        #1;
    endtask

    // Entered #1 after the accepting edge; returns at the negedge of the frame_done cycle.
    task automatic watch_frame(input logic [7:0] d, input logic hold, input logic [7:0] nd);
        int ir_bad = 0, fd_bad = 0, pulses = 0, run = 0, maxw = 0, exp_pulses = 0;
        logic prev = 1'b0;
        logic [15:0] zero_seen = '0;
        logic [7:0] dec = '0;
        tx_data  = hold ? nd : 8'($urandom);
        tx_valid = hold;
        for (int k = 0; k <= NBITS * P; k++) begin
            @(negedge clock);
            if (k == 0) begin
                check("busy_start", 32'(busy), 32'd1);
                check("enable_start", 32'(baud_enable), 32'd1);
                check("ready_start", 32'(tx_ready), 32'd0);
            end
            if (ir_tx !== exp_ir(d, k)) ir_bad++;
            if (frame_done !== (k == NBITS * P)) fd_bad++;
            if (ir_tx && !prev) pulses++;
            run = ir_tx ? run + 1 : 0;
            if (run > maxw) maxw = run;
            if (ir_tx && k >= 1) zero_seen[(k - 1) / P] = 1'b1;
            prev = ir_tx;
        end
        for (int i = 0; i < NBITS; i++) if (!exp_bit(d, i)) exp_pulses++;
        for (int i = 0; i < DB; i++) dec[i] = !zero_seen[i + 1];
        check("ir_wave_mismatch_cycles", 32'(ir_bad), 32'd0);
        check("frame_done_timing_errors", 32'(fd_bad), 32'd0);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        check("pulse_width", 32'(maxw), (exp_pulses > 0) ? 32'(W) : 32'd0);
        check("decoded_byte", 32'(dec & MASK), 32'(d & MASK));
`ifdef IR_TX_PARITY_EN
        check("parity_zero_pulse", 32'(zero_seen[DB + 1]), 32'(~^(d & MASK)));
`endif
        check("busy_end", 32'(busy), 32'd0);
        check("enable_end", 32'(baud_enable), 32'd0);
        check("ready_end", 32'(tx_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int hits;

        repeat (3) @(negedge clock);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_baud_enable", 32'(baud_enable), 32'd0);
        check("rst_ir_tx", 32'(ir_tx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b1;

        // Idle with noisy generator outputs: nothing may react.
        hits = 0;
        repeat (40) begin
            @(negedge clock);
            if (ir_tx || busy || baud_enable || frame_done || !tx_ready) hits++;
        end
        check("idle_noise_ignored", 32'(hits), 32'd0);

        do_accept(8'h55); watch_frame(8'h55, 1'b0, 8'h00);
        do_accept(8'hFF); watch_frame(8'hFF, 1'b0, 8'h00);
        do_accept(8'h00); watch_frame(8'h00, 1'b0, 8'h00);

        // Back-to-back with tx_valid held: a single idle gap cycle.
        do_accept(8'hA5); watch_frame(8'hA5, 1'b1, 8'h3C);
        @(posedge clock);
        #1;
        check("b2b_enable_after_gap", 32'(baud_enable), 32'd1);
        watch_frame(8'h3C, 1'b0, 8'h00);

        repeat (4) begin
            d = 8'($urandom);
            do_accept(d);
            watch_frame(d, 1'b0, 8'h00);
        end

        // Reset inside data bit 4 of 0x00 while a pulse is being emitted.
        do_accept(8'h00);
        tx_valid = 1'b0;
        repeat (5 * P + WS + 4) @(negedge clock);
        check("ir_high_before_reset", 32'(ir_tx), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ir_tx", 32'(ir_tx), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_enable", 32'(baud_enable), 32'd0);
        hits = 0;
        repeat (5) begin
            @(negedge clock);
            if (frame_done) hits++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (frame_done) hits++;
        end
        check("no_frame_done_after_abort", 32'(hits), 32'd0);
        check("ready_after_reset", 32'(tx_ready), 32'd1);
        do_accept(8'h0F); watch_frame(8'h0F, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_tx_sequencer.md
Name: ir_tx_sequencer

Overview:
- IrDA SIR transmit controller; sequences the IR baud generator (enable in; full_baud/pulse ticks out) to serialise one byte per frame onto the IR LED drive.
- Accepts bytes via valid/ready; frame = start bit (0), DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits (1).
- A 0 bit emits the generator's 3/16-width pulse window on ir_tx; a 1 bit emits no light. Sits between the UART-side byte source and the IR transceiver pin.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
STOP_BITS, 1, stop-bit periods per frame (1..2)

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
tx_data  in  DATA_BITS  byte to send, sampled on accept
tx_valid  in  1  source has a byte
tx_ready  out  1  block can accept; accept = tx_valid & tx_ready at posedge
baud_enable  out  1  drives baud generator enable; low clears its counter
baud_full  in  1  one-cycle end-of-bit tick from generator
baud_pulse  in  1  generator 3/16-width pulse window
ir_tx  out  1  IR LED drive, active-high
busy  out  1  frame in progress
frame_done  out  1  one-cycle strobe after last stop period

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; tx_ready=1; baud_enable=0; ir_tx=0; busy=0; frame_done=0; shift register and counters 0.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: tx_ready=1, baud_enable=0, busy=0. On accept: latch tx_data to shift reg, bit_cnt=0, go START. baud_enable and busy rise on the next clock edge.
- START/DATA/PARITY/STOP: tx_ready=0, baud_enable=1, busy=1. Current bit cur_bit: START=0; DATA=shift[0]; PARITY=parity bit; STOP=1.
- Advance only on baud_full=1. Each state/bit therefore lasts one full generator period (5208 clocks at default generator config).
- START -> DATA on baud_full.
- DATA: on baud_full, shift right, bit_cnt+1; when bit_cnt==DATA_BITS-1, go PARITY if enabled, else STOP.
- STOP: stop_cnt counts baud_full. On the STOP_BITS-th tick: go IDLE, pulse frame_done for 1 cycle, clear baud_enable (generator counter clears). At least one IDLE cycle between frames; back-to-back frames are separated by exactly one IDLE cycle when tx_valid is held.
- ir_tx is registered: ir_tx <= (state!=IDLE) & ~cur_bit & baud_pulse. One-clock latency relative to baud_pulse. Never high in IDLE or STOP.
- baud_full/baud_pulse while baud_enable=0 are ignored.
- tx_data changes after accept have no effect on the frame in flight.
- Reset mid-frame: frame aborted immediately; ir_tx=0 asynchronously; no frame_done.
- bit_cnt width: clog2(DATA_BITS); no wrap beyond DATA_BITS-1.

Optional Feature:
- Macro IR_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA for one baud period. Parity bit = even parity (XOR of the latched data bits), so a data byte with odd weight sends parity 1. Frame length = 1+DATA_BITS+1+STOP_BITS periods.
- Undefined: PARITY state and XOR logic absent; DATA -> STOP directly.

Test Plan:
- Generator instanced, default config. Send 0x55 (STOP_BITS=1, no parity) -> 5 ir_tx pulses, each 977 clocks wide (start + 4 zero bits). Frame_done ~52080 clocks (10 x 5208) after accept; ir_tx low during stop.
- Send 0xFF -> exactly 1 pulse (start bit); send 0x00 -> 9 pulses at 5208-clock spacing.
- tx_valid held with 0xA5 then 0x3C -> second accept exactly 1 cycle after frame_done. baud_enable low for exactly that 1 cycle; decoded bytes match.
- Assert reset=0 during data bit 4 of 0x00 -> ir_tx, busy, baud_enable drop without waiting for a clock. After release, tx_ready=1 and the next frame (0x0F) is correct.
- IR_TX_PARITY_EN defined: 0x01 -> parity 1, no pulse in period 10; 0x03 -> parity 0, pulse in period 10; frame_done at 11 x 5208 clocks.
- STOP_BITS=2: 0x80 -> 8 pulses; frame_done 11 x 5208 clocks after accept.
